// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID forward-select encodings and the per-stage
// producer tag that the hazard tracker keeps for EX, MEM and WB.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipe_pkg;

  // ID comparator operand source. The youngest producer wins (EX > MEM > WB).
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_EX  = 2'b11;

  // Tag storage width for the destination index. Narrower register indices
  // are zero-extended into it, so any REG_W up to this value is supported.
  localparam int TAG_RD_W = 8;

  typedef struct packed {
    logic                v;   // a real instruction occupies the stage
    logic [TAG_RD_W-1:0] rd;  // destination register index
    logic                wr;  // instruction writes rd
    logic                ld;  // instruction is a load (data ready after MEM)
  } stage_tag_t;

  localparam stage_tag_t TAG_EMPTY = '0;

  // A stage produces register r when it holds a valid writer of r.
  // Register 0 is hardwired and is never produced.
  function automatic logic tag_hit(input stage_tag_t t,
                                   input logic [TAG_RD_W-1:0] r);
    return t.v && t.wr && (t.rd != '0) && (t.rd == r);
  endfunction

  // Operand source for one ID source given its per-stage hits.
  // A load in EX or MEM has no value to hand over yet, so it is skipped and
  // an older producer is considered instead; the stall logic covers the
  // cases where that older value would be stale.
  function automatic logic [1:0] fwd_sel(input logic hit_ex,
                                         input logic ld_ex,
                                         input logic hit_mem,
                                         input logic ld_mem,
                                         input logic hit_wb);
    if (hit_ex && !ld_ex)        return FWD_EX;
    else if (hit_mem && !ld_mem) return FWD_MEM;
    else if (hit_wb)             return FWD_WB;
    else                         return FWD_REG;
  endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline-stage producer tag register.
// Latency: d appears on q one clock after capture; reset clears q immediately.
// Backpressure: hold=1 freezes the tag (global memory-wait freeze).
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset, clears the tag (v=0)
//   hold  - keep the current tag
//   d     - tag to load when not holding
//   q     - current tag
module stage_tag_reg
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  stage_tag_t d,
  output stage_tag_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= TAG_EMPTY;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_hazard_tracker.sv
// Tracks producers in EX/MEM/WB; generates ID stall and ID forward selects.
// Latency: Stall and *_Src are combinational; tags advance one clock later.
// Backpressure: hold freezes tags and counter; Stall bubbles EX and holds PC/IF-ID.
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   hold                  - global freeze; outputs stay combinationally driven
//   ID_valid              - ID holds a real instruction
//   ID_rs/ID_rt           - source indices; ID_use_rs/ID_use_rt qualify them
//   ID_early              - sources consumed in ID (branch compare, jr)
//   ID_rd, ID_RegWrite,
//   ID_MemRead            - destination of the ID instruction, written into EX tag
//   Stall                 - hold PC and IF/ID, insert bubble into EX
//   ID_rs_Src/ID_rt_Src   - 00 regfile, 01 WB, 10 MEM, 11 EX
//   stall_count           - saturating count of stall cycles
module id_hazard_tracker
  import pipe_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              ID_valid,
  input  logic [REG_W-1:0]  ID_rs,
  input  logic [REG_W-1:0]  ID_rt,
  input  logic              ID_use_rs,
  input  logic              ID_use_rt,
  input  logic              ID_early,
  input  logic [REG_W-1:0]  ID_rd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  output logic              Stall,
  output logic [1:0]        ID_rs_Src,
  output logic [1:0]        ID_rt_Src,
  output logic [PERF_W-1:0] stall_count
);

  stage_tag_t ex_q, mem_q, wb_q;
  stage_tag_t ex_d;

  logic [TAG_RD_W-1:0] rs_idx, rt_idx;

  // Per-source, per-stage hits, already qualified by the source being used.
  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;

  logic load_use, alu_early, load_early;
  logic stall;

  logic [PERF_W-1:0] stall_cnt_q;

  assign rs_idx = TAG_RD_W'(ID_rs);
  assign rt_idx = TAG_RD_W'(ID_rt);

  assign ex_rs  = ID_use_rs && tag_hit(ex_q,  rs_idx);
  assign ex_rt  = ID_use_rt && tag_hit(ex_q,  rt_idx);
  assign mem_rs = ID_use_rs && tag_hit(mem_q, rs_idx);
  assign mem_rt = ID_use_rt && tag_hit(mem_q, rt_idx);
  assign wb_rs  = ID_use_rs && tag_hit(wb_q,  rs_idx);
  assign wb_rt  = ID_use_rt && tag_hit(wb_q,  rt_idx);

  always_comb begin
    // Load in EX: its data does not exist until end of MEM, for any consumer.
    load_use   = (ex_rs || ex_rt) && ex_q.ld;
    // ALU result in EX is produced too late for the ID compare.
    alu_early  = ID_early && (ex_rs || ex_rt) && !ex_q.ld;
    // Load in MEM is still too late for the ID compare. A younger EX producer
    // of the same register shadows it (and is handled by the rules above).
    load_early = ID_early && mem_q.ld &&
                 ((mem_rs && !ex_rs) || (mem_rt && !ex_rt));
    stall      = ID_valid && (load_use || alu_early || load_early);
  end

  assign Stall = stall;

  // Selects are computed even while stalling; the consumer ignores them then.
  assign ID_rs_Src = ID_valid ? fwd_sel(ex_rs, ex_q.ld, mem_rs, mem_q.ld, wb_rs)
                              : FWD_REG;
  assign ID_rt_Src = ID_valid ? fwd_sel(ex_rt, ex_q.ld, mem_rt, mem_q.ld, wb_rt)
                              : FWD_REG;

  // A stalled ID instruction stays in ID; EX receives a bubble instead.
  always_comb begin
    ex_d    = TAG_EMPTY;
    ex_d.v  = ID_valid && !stall;
    ex_d.rd = TAG_RD_W'(ID_rd);
    ex_d.wr = ID_RegWrite;
    ex_d.ld = ID_MemRead;
  end

  stage_tag_reg u_ex_tag (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .d     (ex_d),
    .q     (ex_q)
  );

  stage_tag_reg u_mem_tag (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .d     (ex_q),
    .q     (mem_q)
  );

  stage_tag_reg u_wb_tag (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .d     (mem_q),
    .q     (wb_q)
  );

  // Only stall cycles that actually elapse (not frozen) are counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !hold && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_tracker.sv
module tb_id_hazard_tracker;

  localparam int RW = 5;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          hold;
  logic          ID_valid;
  logic [RW-1:0] ID_rs, ID_rt, ID_rd;
  logic          ID_use_rs, ID_use_rt, ID_early;
  logic          ID_RegWrite, ID_MemRead;
  logic          Stall;
  logic [1:0]    ID_rs_Src, ID_rt_Src;
  logic [PW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_hazard_tracker #(.REG_W(RW), .PERF_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .ID_valid    (ID_valid),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_use_rs   (ID_use_rs),
    .ID_use_rt   (ID_use_rt),
    .ID_early    (ID_early),
    .ID_rd       (ID_rd),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .Stall       (Stall),
    .ID_rs_Src   (ID_rs_Src),
    .ID_rt_Src   (ID_rt_Src),
    .stall_count (stall_count)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [PW-1:0] obs, input int exp);
    checks++;
    assert (obs === PW'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one ID instruction.
  task automatic id(input logic v, input logic [RW-1:0] rs, input logic urs,
                    input logic [RW-1:0] rt, input logic urt, input logic early,
                    input logic [RW-1:0] rd, input logic wr, input logic ld);
    ID_valid = v;   ID_rs = rs;  ID_use_rs = urs; ID_rt = rt; ID_use_rt = urt;
    ID_early = early; ID_rd = rd; ID_RegWrite = wr; ID_MemRead = ld;
  endtask

  task automatic lw(input logic [RW-1:0] rd);
    id(1, 5'd29, 1, 5'd0, 0, 0, rd, 1, 1);
  endtask

  task automatic alu(input logic [RW-1:0] rd, input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    id(1, rs, 1, rt, 1, 0, rd, 1, 0);
  endtask

  task automatic beq(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    id(1, rs, 1, rt, 1, 1, 5'd0, 0, 0);
  endtask

  task automatic idle;
    id(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    idle();
    repeat (4) next_cyc();
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    idle();

    // ---------------- reset with random ID activity ----------------
    for (int i = 0; i < 3; i++) begin
      id(1, RW'($urandom), 1'($urandom), RW'($urandom), 1'($urandom),
         1'($urandom), RW'($urandom), 1'($urandom), 1'($urandom));
      sample();
      chk1("rst_stall", Stall, 1'b0);
      chk2("rst_rs_src", ID_rs_Src, 2'b00);
      chk2("rst_rt_src", ID_rt_Src, 2'b00);
      chkc("rst_count", stall_count, 0);
      next_cyc();
    end
    reset = 1'b1;
    beq(5'd3, 5'd4);
    sample();
    chk1("post_rst_stall", Stall, 1'b0);
    chk2("post_rst_rs_src", ID_rs_Src, 2'b00);
    next_cyc();
    flush();

    // ---------------- load-use, normal consumer ----------------
    lw(5'd8);
    sample();
    chk1("lu_lw_stall", Stall, 1'b0);
    next_cyc();
    alu(5'd10, 5'd8, 5'd9);
    sample();
    chk1("lu_stall1", Stall, 1'b1);
    next_cyc();
    sample();
    chk1("lu_stall2", Stall, 1'b0);
    chk2("lu_rs_src", ID_rs_Src, 2'b00);
    chkc("lu_count", stall_count, 1);
    next_cyc();
    flush();

    // ---------------- load then branch ----------------
    lw(5'd9);
    next_cyc();
    beq(5'd4, 5'd9);
    sample();
    chk1("lb_stall1", Stall, 1'b1);
    next_cyc();
    sample();
    chk1("lb_stall2", Stall, 1'b1);
    next_cyc();
    sample();
    chk1("lb_stall3", Stall, 1'b0);
    chk2("lb_rt_src", ID_rt_Src, 2'b01);
    chk2("lb_rs_src", ID_rs_Src, 2'b00);
    chkc("lb_count", stall_count, 3);
    next_cyc();
    flush();

    // ---------------- ALU, nop, branch ----------------
    alu(5'd5, 5'd1, 5'd2);
    next_cyc();
    id(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    next_cyc();
    beq(5'd5, 5'd6);
    sample();
    chk1("anb_stall", Stall, 1'b0);
    chk2("anb_rs_src", ID_rs_Src, 2'b10);
    chk2("anb_rt_src", ID_rt_Src, 2'b00);
    next_cyc();
    flush();

    // ---------------- ALU then branch back-to-back ----------------
    alu(5'd5, 5'd1, 5'd2);
    next_cyc();
    beq(5'd5, 5'd6);
    sample();
    chk1("ab_stall1", Stall, 1'b1);
    next_cyc();
    sample();
    chk1("ab_stall2", Stall, 1'b0);
    chk2("ab_rs_src", ID_rs_Src, 2'b10);
    chkc("ab_count", stall_count, 4);
    next_cyc();
    flush();

    // ---------------- priority EX > MEM > WB ----------------
    alu(5'd7, 5'd1, 5'd2);
    next_cyc();
    alu(5'd7, 5'd1, 5'd2);
    next_cyc();
    alu(5'd11, 5'd7, 5'd3);
    sample();
    chk1("pri_stall", Stall, 1'b0);
    chk2("pri_ex_rs_src", ID_rs_Src, 2'b11);
    chk2("pri_ex_rt_src", ID_rt_Src, 2'b00);
    next_cyc();
    alu(5'd12, 5'd7, 5'd7);
    sample();
    chk2("pri_mem_rs_src", ID_rs_Src, 2'b10);
    chk2("pri_mem_rt_src", ID_rt_Src, 2'b10);
    next_cyc();
    flush();

    // ---------------- register 0 in every stage ----------------
    alu(5'd0, 5'd1, 5'd2);
    next_cyc();
    alu(5'd0, 5'd1, 5'd2);
    next_cyc();
    lw(5'd0);
    next_cyc();
    beq(5'd0, 5'd0);
    sample();
    chk1("r0_stall", Stall, 1'b0);
    chk2("r0_rs_src", ID_rs_Src, 2'b00);
    chk2("r0_rt_src", ID_rt_Src, 2'b00);
    next_cyc();
    flush();

    // ---------------- hold during load-use stall ----------------
    lw(5'd8);
    next_cyc();
    alu(5'd10, 5'd8, 5'd0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk1("hold_stall", Stall, 1'b1);
      chkc("hold_count", stall_count, 4);
      next_cyc();
    end
    hold = 1'b0;
    sample();
    chk1("hold_rel_stall", Stall, 1'b1);
    next_cyc();
    sample();
    chk1("hold_done_stall", Stall, 1'b0);
    chk2("hold_rs_src", ID_rs_Src, 2'b00);
    chkc("hold_done_count", stall_count, 5);
    next_cyc();
    flush();

    // ---------------- valid / use gating ----------------
    alu(5'd12, 5'd1, 5'd2);
    next_cyc();
    id(0, 5'd12, 1, 5'd12, 1, 1, 5'd0, 0, 0);
    sample();
    chk1("gate_inv_stall", Stall, 1'b0);
    chk2("gate_inv_rs_src", ID_rs_Src, 2'b00);
    next_cyc();
    id(1, 5'd12, 0, 5'd12, 1, 1, 5'd0, 0, 0);
    sample();
    chk1("gate_use_stall", Stall, 1'b0);
    chk2("gate_use_rs_src", ID_rs_Src, 2'b00);
    chk2("gate_use_rt_src", ID_rt_Src, 2'b10);
    chkc("gate_count", stall_count, 5);
    next_cyc();
    flush();

    // ---------------- reset asserted mid-stall ----------------
    lw(5'd9);
    next_cyc();
    beq(5'd9, 5'd9);
    sample();
    chk1("mrst_pre_stall", Stall, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("mrst_stall", Stall, 1'b0);
    chkc("mrst_count", stall_count, 0);
    next_cyc();
    reset = 1'b1;
    sample();
    chk1("mrst_after_stall", Stall, 1'b0);
    next_cyc();
    flush();

    // ---------------- counter saturation ----------------
    // Each iteration: lw $8 then a dependent beq that stalls for 2 cycles.
    for (int i = 0; i < 31; i++) begin
      lw(5'd8);
      next_cyc();
      beq(5'd8, 5'd0);
      next_cyc();
      next_cyc();
    end
    sample();
    chkc("sat_pre_count", stall_count, 62);
    for (int i = 0; i < 4; i++) begin
      lw(5'd8);
      next_cyc();
      beq(5'd8, 5'd0);
      next_cyc();
      next_cyc();
    end
    sample();
    chkc("sat_count", stall_count, 63);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
